// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: LSB-first bit stream with FRAME/LAST markers.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             FRAME,
  output logic             LAST
);

`ifdef PISO_TX_PARITY_EN
  localparam int unsigned FLEN = WIDTH + 1;
`else
  localparam int unsigned FLEN = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t          r_state;
  logic [FLEN-1:0] r_shift;
  logic [CW-1:0]   r_cnt;
  logic            r_sout;
  logic            r_svalid;
  logic            r_frame;
  logic            r_last;
  logic            r_ready;

  logic [FLEN-1:0] w_frame;
  logic            w_accept;
  logic            w_last_bit;
  logic            w_next_last;

`ifdef PISO_TX_PARITY_EN
  assign w_frame = {^DIN, DIN};
`else
  assign w_frame = DIN;
`endif

  assign w_accept    = LOAD_VALID & r_ready;
  assign w_last_bit  = (r_cnt == CW'(FLEN - 1));
  assign w_next_last = (r_cnt == CW'(FLEN - 2));

  // Bit 0 goes straight to SOUT on accept; r_shift holds the bits still to send.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_sout   <= 1'b0;
      r_svalid <= 1'b0;
      r_frame  <= 1'b0;
      r_last   <= 1'b0;
      r_ready  <= 1'b1;
    end else if (w_accept) begin
      r_state  <= ST_SHIFT;
      r_shift  <= w_frame >> 1;
      r_cnt    <= '0;
      r_sout   <= DIN[0];
      r_svalid <= 1'b1;
      r_frame  <= 1'b1;
      r_last   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (w_last_bit) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_sout   <= 1'b0;
            r_svalid <= 1'b0;
            r_frame  <= 1'b0;
            r_last   <= 1'b0;
            r_ready  <= 1'b1;
          end else begin
            r_shift  <= {1'b0, r_shift[FLEN-1:1]};
            r_cnt    <= r_cnt + CW'(1);
            r_sout   <= r_shift[0];
            r_frame  <= 1'b0;
            r_last   <= w_next_last;
            r_ready  <= w_next_last;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_sout   <= 1'b0;
          r_svalid <= 1'b0;
          r_frame  <= 1'b0;
          r_last   <= 1'b0;
          r_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign LOAD_READY = r_ready;
  assign SOUT       = r_sout;
  assign SVALID     = r_svalid;
  assign FRAME      = r_frame;
  assign LAST       = r_last;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: expected bits are queued per accepted word and popped each cycle.
module tb_piso_shift_tx;

  localparam int unsigned W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int unsigned N = W + 1;
`else
  localparam int unsigned N = W;
`endif

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic [W-1:0] DIN = '0;
  logic         LOAD_VALID = 1'b0;
  logic         LOAD_READY, SOUT, SVALID, FRAME, LAST;

  // Entry = {sout, frame, last}
  logic [2:0] q[$];
  int n_pass = 0;
  int n_total = 0;

  piso_shift_tx #(.WIDTH(W)) dut (
    .CLK(CLK), .RSTn(RSTn), .DIN(DIN), .LOAD_VALID(LOAD_VALID),
    .LOAD_READY(LOAD_READY), .SOUT(SOUT), .SVALID(SVALID),
    .FRAME(FRAME), .LAST(LAST)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
  endtask

  task automatic push_word(input logic [W-1:0] d);
    logic b;
    for (int i = 0; i < int'(N); i++) begin
      b = (i < int'(W)) ? d[i] : ^d;
      q.push_back({b, i == 0, i == int'(N) - 1});
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_svalid"}, SVALID, 1'b0);
    chk({tag, "_sout"},   SOUT,   1'b0);
    chk({tag, "_frame"},  FRAME,  1'b0);
    chk({tag, "_last"},   LAST,   1'b0);
    chk({tag, "_ready"},  LOAD_READY, 1'b1);
  endtask

  // Drive inputs, cross one edge, then compare against the head of the queue.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d);
    logic acc;
    logic [2:0] e;
    LOAD_VALID = v;
    DIN = d;
    acc = v && (q.size() == 0);
    @(posedge CLK);
    if (acc) push_word(d);
    #1;
    if (q.size() == 0) begin
      check_idle(tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_svalid"}, SVALID, 1'b1);
      chk({tag, "_sout"},   SOUT,   e[2]);
      chk({tag, "_frame"},  FRAME,  e[1]);
      chk({tag, "_last"},   LAST,   e[0]);
      chk({tag, "_ready"},  LOAD_READY, e[0]);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < int'(N) + 2; i++) step(tag, 1'b0, '0);
  endtask

  initial begin
    // Reset held across two edges, then released between edges
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_idle("rst_held");
    #4 RSTn = 1'b1;
    @(posedge CLK);
    #1;
    check_idle("rst_rel");

    step("a5", 1'b1, 8'hA5);
    drain("a5");

    step("b2b", 1'b1, 8'h3C);
    for (int i = 0; i < int'(N); i++) step("b2b", 1'b1, 8'hFF);
    drain("b2b");

    // Request while busy must wait for the LAST edge
    step("busy", 1'b1, 8'h81);
    step("busy", 1'b0, 8'h81);
    for (int i = 0; i < int'(N) - 1; i++) step("busy", 1'b1, 8'h00);
    drain("busy");

    // Asynchronous reset mid-frame
    step("mrst", 1'b1, 8'hF0);
    for (int i = 0; i < 4; i++) step("mrst", 1'b0, 8'h00);
    #2 RSTn = 1'b0;
    #1;
    check_idle("mrst_async");
    q.delete();
    @(posedge CLK);
    #1;
    check_idle("mrst_hold");
    #2 RSTn = 1'b1;
    step("mrst_0f", 1'b1, 8'h0F);
    drain("mrst_0f");

`ifdef PISO_TX_PARITY_EN
    step("par07", 1'b1, 8'h07);
    drain("par07");
    step("par03", 1'b1, 8'h03);
    drain("par03");
`endif

    for (int k = 0; k < 4; k++) begin
      step("rnd", 1'b1, W'($urandom));
      while (q.size() != 0) step("rnd", 1'b0, '0);
    end
    drain("rnd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
